// File: rtl/leds_pkg.sv
// -----------------------------------------------------------------------------
// leds_pkg
// Shared definitions for the multi-channel LED driver.
//   MODE_W        width of one channel's mode field
//   mode_e        per-channel operating mode (OFF, ON, BLINK, FLASH)
//   led_for_mode  maps a mode plus channel state to the LED level
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package leds_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FLASH = 2'd3
    } mode_e;

    // LED level for a channel given its mode, blink phase and whether its
    // tick counter sits at zero (the FLASH strobe point).
    function automatic logic led_for_mode(mode_e m, logic phase, logic at_zero);
        logic lvl;
        unique case (m)
            MODE_OFF:   lvl = 1'b0;
            MODE_ON:    lvl = 1'b1;
            MODE_BLINK: lvl = phase;
            MODE_FLASH: lvl = at_zero;
            default:    lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/leds_channel.sv
// -----------------------------------------------------------------------------
// leds_channel
// One LED channel: tick counter, blink phase, last-seen mode and the
// registered LED output.
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   tick    one-cycle prescaler strobe
//   sync    synchronous restart of count and phase
//   mode    requested mode (leds_pkg::mode_e encoding)
//   period  period in ticks; 0 is treated as 1
//   led     registered LED output
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module leds_channel
    import leds_pkg::*;
#(
    parameter int unsigned PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                sync,
    input  logic [MODE_W-1:0]   mode,
    input  logic [PERIOD_W-1:0] period,
    output logic                led
);

    logic [PERIOD_W-1:0] count_q, count_d;
    logic                phase_q, phase_d;
    mode_e               mode_q,  mode_d;
    logic                led_q,   led_d;

    mode_e               mode_in;
    logic [PERIOD_W-1:0] last;
    logic                wrap;

    always_comb begin
        mode_in = mode_e'(mode);

        // Last count value of a period; period 0 behaves as period 1.
        last = (period == '0) ? '0 : (period - PERIOD_W'(1));

        // >= rather than == so a period shortened mid-count still wraps.
        wrap = (count_q >= last);

        count_d = count_q;
        phase_d = phase_q;
        mode_d  = mode_q;

        if (sync) begin
            // Sync outranks both a mode change and a coincident tick.
            count_d = '0;
            phase_d = 1'b0;
            mode_d  = mode_in;
        end else if (mode_in != mode_q) begin
            count_d = '0;
            phase_d = 1'b0;
            mode_d  = mode_in;
        end else if (tick) begin
            unique case (mode_q)
                MODE_BLINK: begin
                    if (wrap) begin
                        count_d = '0;
                        phase_d = ~phase_q;
                    end else begin
                        count_d = count_q + PERIOD_W'(1);
                    end
                end
                MODE_FLASH: begin
                    if (wrap) begin
                        count_d = '0;
                    end else begin
                        count_d = count_q + PERIOD_W'(1);
                    end
                end
                default: begin
                    // OFF / ON: counters are idle; re-entry clears them anyway.
                end
            endcase
        end

        // LED is derived from the next state so it updates on the same edge.
        led_d = led_for_mode(mode_d, phase_d, (count_d == '0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            phase_q <= 1'b0;
            mode_q  <= MODE_OFF;
            led_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/leds_blink.sv
// -----------------------------------------------------------------------------
// leds_blink
// Multi-channel LED driver with a shared prescaler, per-channel mode and
// period, and a global phase-sync input.
// Ports:
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   en      global enable; 0 freezes prescaler and channel counters
//   sync    synchronous restart of prescaler and all channel phases
//   mode    per-channel mode, channel i at [2i+1:2i]
//   period  per-channel period in ticks, channel i at [PERIOD_W*i +: PERIOD_W]
//   led     registered LED outputs
//   tick    one-cycle prescaler strobe
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module leds_blink
    import leds_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned PERIOD_W = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         sync,
    input  logic [MODE_W*CHANNELS-1:0]   mode,
    input  logic [PERIOD_W*CHANNELS-1:0] period,
    output logic [CHANNELS-1:0]          led,
    output logic                         tick
);

    localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Decoded from registered state only, so it is a clean one-cycle pulse.
    assign tick = en && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (sync) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : (pre_q + PRE_W'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        leds_channel #(
            .PERIOD_W (PERIOD_W)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .tick   (tick),
            .sync   (sync),
            .mode   (mode[MODE_W*i +: MODE_W]),
            .period (period[PERIOD_W*i +: PERIOD_W]),
            .led    (led[i])
        );
    end

endmodule

// File: doc/leds_blink.md
# leds_blink

Parametrised multi-channel LED driver for the board-level indicator outputs. It replaces the single free-running LED toggle with the following features:
- a shared prescaler;
- a per-channel mode (off, on, blink, flash);
- a per-channel programmable period;
- a global phase-sync input.

All LED outputs are registered and glitch-free. The block sits between the control registers and the LED pins.

## Interface
Parameters:
- CHANNELS, 4, number of independent LED channels
- PRESCALE, 1000, clk cycles per tick (>= 2)
- PERIOD_W, 8, width of each channel's period field

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  global enable; 0 freezes prescaler and all channel counters
- sync  in  1  synchronous restart of prescaler and all channel phases
- mode  in  2*CHANNELS  per-channel mode, channel i at [2i+1:2i]
- period  in  PERIOD_W*CHANNELS  per-channel period in ticks, channel i at [PERIOD_W*i +: PERIOD_W]
- led  out  CHANNELS  registered LED outputs
- tick  out  1  prescaler strobe

## Operation
- Prescaler `pre` counts 0..PRESCALE-1 while en=1.
- `tick` = en && pre==PRESCALE-1. It is combinational from registered state and is high for exactly one clk cycle.
- Each channel holds the following state:
  - count (PERIOD_W bits);
  - phase (1 bit);
  - mode_q (last mode seen).
- Effective period P = max(period_i, 1).
- Modes:
  - 0 OFF: led_i=0.
  - 1 ON: led_i=1.
  - 2 BLINK: on each tick, if count >= P-1 then count<=0 and phase<=~phase, else count<=count+1. led_i = phase. One half-period is P ticks; the full cycle is 2P ticks.
  - 3 FLASH: on each tick, if count >= P-1 then count<=0, else count<=count+1. led_i = (next count == 0), giving a one-tick flash every P ticks. For P=1, led_i is constant 1.
- Mode change: when mode_i != mode_q on an edge, the channel clears count and phase to 0 and loads mode_q. This takes priority over a tick in the same cycle.
- Period change mid-count takes effect at the next tick. The >= compare guarantees a wrap even when count exceeds the new P-1.
- en=0: pre, count and phase all hold. OFF/ON outputs still follow mode.
- Priority per edge, highest first:
  1. reset
  2. sync (clears pre, all counts and all phases; no toggle even if tick is high)
  3. mode change
  4. tick

## Timing
- Reset (async, low): pre=0, count=0, phase=0, mode_q=0 (OFF), led=0, tick=0. Takes effect immediately, independent of clk.
- First tick after reset release with en=1: pre reaches PRESCALE-1 during the PRESCALE-th cycle.
- LED latency: led_i updates on the same clk edge at which tick is sampled high (one registered stage).
- BLINK: led rises on the P-th tick edge after reset, sync or mode entry, then toggles every P ticks.
- Mode change latency: led reflects the new mode's reset state on the first edge after mode changes.
- Counter wrap: count never exceeds 2^PERIOD_W-1.

## Structure
- Package leds_pkg:
  - MODE_W=2
  - MODE_OFF=2'd0, MODE_ON=2'd1, MODE_BLINK=2'd2, MODE_FLASH=2'd3
  - a mode typedef
- Sub-module leds_channel:
  - holds one channel's count, phase, mode_q and led register;
  - inputs: clk, reset, tick, sync, mode, period;
  - instantiated CHANNELS times by generate.
- The prescaler, tick generation and port slicing live in leds_blink.

## Test plan
All scenarios use PRESCALE=4, CHANNELS=2, PERIOD_W=4.
- Reset mid-blink: reset low while led[0]=1 -> led=0 and tick=0 immediately, before the next clk edge. After release, the first tick occurs at cycle 4.
- BLINK, period=3, en=1 from reset release -> led[0] rises at clk edge 12, falls at 24, rises at 36. tick pulses every 4 cycles.
- FLASH, period=4 -> led[1] high for 4 cycles out of every 16. With period=0, led[1] is constant 1.
- Mode switch BLINK->ON->BLINK with led=1 -> led=1 (ON), then 0 one edge after re-entering BLINK. The next rise comes P ticks later.
- sync coincident with tick at count=P-1 -> no toggle; pre and count return to 0. The next toggle comes a full P ticks later.
- en=0 for 20 cycles mid-period -> tick stays 0 and led/count hold. Counting resumes from the held values when en returns to 1.
